// File: rtl/branch_pkg.sv
// Shared types and defaults for the registered branch-condition unit.
// Feature macro: BRANCH_FLAG_FORWARD_EN (see branch_resolver).
package branch_pkg;

  localparam int NUM_FLAGS_D = 6;
  localparam int COND_W_D    = 4;
  localparam int CNT_W_D     = 8;

  localparam int COND_ALWAYS = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  function automatic logic cond_in_range(
    input int code,
    input int nflags
  );
    return code <= nflags;
  endfunction

endpackage

// File: rtl/branch_resolver_cond_eval.sv
// Combinational condition evaluator: code/polarity/flags -> jump, error.
// Code 0 is "always"; codes above the flag count are errors.
module cond_eval
  import branch_pkg::*;
#(
  parameter int NUM_FLAGS = NUM_FLAGS_D,
  parameter int COND_W    = COND_W_D
) (
  input  logic [COND_W-1:0]    condicao,
  input  logic                 control,
  input  logic [NUM_FLAGS-1:0] flags,
  output logic                 salto,
  output logic                 cond_err
);

  logic w_bit;

  always_comb begin
    w_bit = 1'b0;
    for (int i = 0; i < NUM_FLAGS; i++) begin
      if (condicao == COND_W'(i + 1)) w_bit = flags[i];
    end
  end

  always_comb begin
    salto    = 1'b0;
    cond_err = 1'b0;
    if (condicao == COND_W'(COND_ALWAYS)) begin
      salto = control;
    end else if (cond_in_range(int'(condicao), NUM_FLAGS)) begin
      salto = control ? w_bit : ~w_bit;
    end else begin
      cond_err = 1'b1;
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Registered branch resolver: flag register, valid/ready request, stall.
// Define BRANCH_FLAG_FORWARD_EN to evaluate against flag_in on write.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int NUM_FLAGS = NUM_FLAGS_D,
  parameter int COND_W    = COND_W_D,
  parameter int CNT_W     = CNT_W_D
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flag_we,
  input  logic [NUM_FLAGS-1:0] flag_in,
  input  logic                 flags_pending,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [COND_W-1:0]    condicao,
  input  logic                 control,
  input  logic                 flush,
  output logic                 salto_valid,
  output logic                 salto,
  output logic                 cond_err,
  output logic [NUM_FLAGS-1:0] flags_q,
  output logic [CNT_W-1:0]     taken_cnt
);

  if ((2 ** COND_W) <= NUM_FLAGS) begin : g_bad_cfg
    $fatal(1, "branch_resolver: 2**COND_W must exceed NUM_FLAGS");
  end

  state_t               r_state;
  state_t               w_next;
  logic [NUM_FLAGS-1:0] r_flags;
  logic [COND_W-1:0]    r_cond;
  logic                 r_pol;
  logic                 r_valid;
  logic                 r_salto;
  logic                 r_err;
  logic [CNT_W-1:0]     r_cnt;

  logic                 w_accept;
  logic                 w_fire;
  logic [COND_W-1:0]    w_cond;
  logic                 w_pol;
  logic [NUM_FLAGS-1:0] w_flags;
  logic                 w_salto;
  logic                 w_err;

  assign req_ready = (r_state == IDLE);
  // flush in IDLE blocks a same-cycle request
  assign w_accept  = req_valid & req_ready & ~flush;

  always_comb begin
    w_next  = r_state;
    w_fire  = 1'b0;
    w_cond  = r_cond;
    w_pol   = r_pol;
    w_flags = r_flags;
    unique case (r_state)
      IDLE: begin
        w_cond = condicao;
        w_pol  = control;
`ifdef BRANCH_FLAG_FORWARD_EN
        if (flag_we) w_flags = flag_in;
`endif
        if (w_accept) begin
          if (flags_pending) w_next = WAIT;
          else               w_fire = 1'b1;
        end
      end
      WAIT: begin
        if (flush) begin
          w_next = IDLE;
        end else if (flag_we) begin
`ifdef BRANCH_FLAG_FORWARD_EN
          w_flags = flag_in;
          w_fire  = 1'b1;
          w_next  = IDLE;
`else
          w_next  = RESOLVE;
`endif
        end
      end
      RESOLVE: begin
        w_next = IDLE;
        w_fire = ~flush;
      end
      default: w_next = IDLE;
    endcase
  end

  cond_eval #(
    .NUM_FLAGS (NUM_FLAGS),
    .COND_W    (COND_W)
  ) u_eval (
    .condicao (w_cond),
    .control  (w_pol),
    .flags    (w_flags),
    .salto    (w_salto),
    .cond_err (w_err)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_flags <= '0;
    end else if (flag_we) begin
      r_flags <= flag_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cond  <= '0;
      r_pol   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept && flags_pending) begin
        r_cond <= condicao;
        r_pol  <= control;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_salto <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_valid <= w_fire;
      r_err   <= w_fire & w_err;
      if (w_fire) r_salto <= w_salto;
      if (w_fire && w_salto && !w_err && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign salto_valid = r_valid;
  assign salto       = r_salto;
  assign cond_err    = r_err;
  assign flags_q     = r_flags;
  assign taken_cnt   = r_cnt;

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver against a behavioural model.
// Honors BRANCH_FLAG_FORWARD_EN when defined for the build.
module tb_branch_resolver;

  logic       clock = 1'b0;
  logic       reset;
  logic       flag_we;
  logic [5:0] flag_in;
  logic       flags_pending;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] condicao;
  logic       control;
  logic       flush;
  logic       salto_valid;
  logic       salto;
  logic       cond_err;
  logic [5:0] flags_q;
  logic [7:0] taken_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  logic [5:0] m_flags;
  int         m_cnt;
  bit         m_salto;

  branch_resolver dut (
    .clock         (clock),
    .reset         (reset),
    .flag_we       (flag_we),
    .flag_in       (flag_in),
    .flags_pending (flags_pending),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .condicao      (condicao),
    .control       (control),
    .flush         (flush),
    .salto_valid   (salto_valid),
    .salto         (salto),
    .cond_err      (cond_err),
    .flags_q       (flags_q),
    .taken_cnt     (taken_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic bit ref_eval(input int c, input bit p,
                                  input logic [5:0] f);
    bit b;
    if (c == 0) return p;
    if (c > 6) return 1'b0;
    b = ((int'(f) >> (c - 1)) % 2) == 1;
    return p ? b : !b;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic post_result(input int c, input bit e);
    chk("res_valid", salto_valid, 1);
    chk("res_salto", salto, e);
    chk("res_err", cond_err, (c > 6));
    m_salto = e;
    if (e) m_cnt = sat_inc(m_cnt);
    chk("res_cnt", taken_cnt, m_cnt);
  endtask

  task automatic flag_write(input logic [5:0] nf);
    flag_we = 1'b1;
    flag_in = nf;
    tick();
    flag_we = 1'b0;
    m_flags = nf;
    chk("fw_flags", flags_q, m_flags);
    chk("fw_valid", salto_valid, 0);
    chk("fw_hold", salto, m_salto);
  endtask

  task automatic do_req(input int c, input bit p, input bit we,
                        input logic [5:0] nf);
    bit e;
    condicao  = c[3:0];
    control   = p;
    req_valid = 1'b1;
    flag_we   = we;
    flag_in   = nf;
    chk("idle_ready", req_ready, 1);
`ifdef BRANCH_FLAG_FORWARD_EN
    e = we ? ref_eval(c, p, nf) : ref_eval(c, p, m_flags);
`else
    e = ref_eval(c, p, m_flags);
`endif
    tick();
    req_valid = 1'b0;
    flag_we   = 1'b0;
    if (we) m_flags = nf;
    post_result(c, e);
    chk("req_flags", flags_q, m_flags);
  endtask

  task automatic pend_req(input int c, input bit p, input int delay,
                          input logic [5:0] nf, input bit fl);
    bit e;
    flags_pending = 1'b1;
    req_valid     = 1'b1;
    condicao      = c[3:0];
    control       = p;
    chk("pend_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("wait_ready", req_ready, 0);
    chk("wait_valid", salto_valid, 0);
    for (int k = 0; k < delay; k++) begin
      flags_pending = 1'($urandom_range(0, 1));
      tick();
      chk("wait_ready", req_ready, 0);
      chk("wait_valid", salto_valid, 0);
    end
    flag_we = 1'b1;
    flag_in = nf;
    flush   = fl;
    e       = ref_eval(c, p, nf);
    tick();
    flag_we       = 1'b0;
    flush         = 1'b0;
    flags_pending = 1'b0;
    m_flags       = nf;
    chk("pend_flags", flags_q, m_flags);
    if (fl) begin
      chk("fl_valid", salto_valid, 0);
      chk("fl_ready", req_ready, 1);
      tick();
      chk("fl_valid2", salto_valid, 0);
      chk("fl_cnt", taken_cnt, m_cnt);
      chk("fl_hold", salto, m_salto);
    end else begin
`ifndef BRANCH_FLAG_FORWARD_EN
      chk("res_early", salto_valid, 0);
      chk("resolve_ready", req_ready, 0);
      tick();
`endif
      post_result(c, e);
      tick();
      chk("one_pulse", salto_valid, 0);
    end
  endtask

  initial begin
    reset = 1'b1; flag_we = 1'b0; flag_in = '0; flags_pending = 1'b0;
    req_valid = 1'b0; condicao = '0; control = 1'b0; flush = 1'b0;
    m_flags = '0; m_cnt = 0; m_salto = 1'b0;
    tick();
    tick();
    chk("rst_valid", salto_valid, 0);
    chk("rst_salto", salto, 0);
    chk("rst_err", cond_err, 0);
    chk("rst_flags", flags_q, 0);
    chk("rst_cnt", taken_cnt, 0);
    chk("rst_ready", req_ready, 1);
    reset = 1'b0;
    tick();

    flag_write(6'b010101);
    do_req(1, 1, 0, '0);
    do_req(2, 1, 0, '0);
    do_req(2, 0, 0, '0);
    chk("cnt_two", taken_cnt, 2);
    do_req(0, 1, 0, '0);
    do_req(0, 0, 0, '0);
    do_req(7, 1, 0, '0);
    tick();
    chk("idle_after", salto_valid, 0);

    pend_req(4, 1, 3, 6'b001000, 0);

    // flush in WAIT with no flag write
    flags_pending = 1'b1; req_valid = 1'b1; condicao = 4'd1; control = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("fw_wait_ready", req_ready, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0; flags_pending = 1'b0;
    chk("flush_ready", req_ready, 1);
    chk("flush_valid", salto_valid, 0);
    tick();
    chk("flush_valid2", salto_valid, 0);
    flag_write(6'b110011);

    // flush in IDLE blocks a same-cycle request
    req_valid = 1'b1; flush = 1'b1; condicao = 4'd0; control = 1'b1;
    tick();
    req_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_valid", salto_valid, 0);
    chk("idle_flush_ready", req_ready, 1);

    flag_write(6'b000000);
    do_req(1, 1, 1, 6'b000001);
    `ifdef BRANCH_FLAG_FORWARD_EN
    chk("fwd_same", salto, 1);
    `else
    chk("fwd_same", salto, 0);
    `endif

    for (int it = 0; it < 150; it++) begin
      int op;
      op = $urandom_range(0, 3);
      case (op)
        0: flag_write(6'($urandom));
        1: do_req($urandom_range(0, 15), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 6'($urandom));
        2: pend_req($urandom_range(0, 15), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 4), 6'($urandom), 0);
        default: pend_req($urandom_range(0, 15), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 4), 6'($urandom), 1);
      endcase
    end

    // reset in WAIT after a taken branch
    do_req(0, 1, 0, '0);
    flag_write(6'b111111);
    flags_pending = 1'b1; req_valid = 1'b1; condicao = 4'd3; control = 1'b1;
    tick();
    req_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("mrst_valid", salto_valid, 0);
    chk("mrst_salto", salto, 0);
    chk("mrst_flags", flags_q, 0);
    chk("mrst_cnt", taken_cnt, 0);
    chk("mrst_ready", req_ready, 1);
    reset = 1'b0; flags_pending = 1'b0;
    m_flags = '0; m_cnt = 0; m_salto = 1'b0;
    tick();

    for (int i = 0; i < 260; i++) do_req(0, 1, 0, '0);
    chk("sat_cnt", taken_cnt, 255);
    do_req(0, 0, 0, '0);
    chk("sat_hold", taken_cnt, 255);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
